// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and byte/word geometry for the program loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR} state_t;
  localparam int BYTE_W = 8;
  localparam int WORD_BYTES = 2;
endpackage

// File: rtl/program_loader.sv
// program_loader: fills program memory from a checksummed byte stream, holding the cpu in reset until success.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = WORD_BYTES * BYTE_W,
  parameter int MAX_WORDS = 65536
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              pm_wr_en,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);
  state_t state, nxt;
  logic [7:0] len_hi, hi, csum;
  logic [15:0] len, idx, n_hdr;
  logic xfer, restart;
  assign n_hdr = {len_hi, s_data};
  assign busy = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  assign s_ready = busy;
  assign done = state == DONE;
  assign error = state == ERROR;
  assign cpu_hold = state != DONE;
  assign xfer = s_valid && s_ready;
  assign restart = start && !busy;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: nxt = restart ? LEN_HI : state;
      LEN_HI:  nxt = xfer ? LEN_LO : state;
      LEN_LO:  nxt = !xfer ? state : n_hdr == '0 ? CHECK :
                     {16'b0, n_hdr} > 32'(MAX_WORDS) ? ERROR : DATA_HI;
      DATA_HI: nxt = xfer ? DATA_LO : state;
      DATA_LO: nxt = !xfer ? state : idx + 16'd1 == len ? CHECK : DATA_HI;
      CHECK:   nxt = !xfer ? state : s_data == csum ? DONE : ERROR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rstn)
    if (rstn) state <= IDLE;
    else state <= nxt;
  // Write port is registered: the word lands the cycle after its LO byte.
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      len_hi <= '0;
      len <= '0;
      hi <= '0;
      csum <= '0;
      idx <= '0;
      pm_wr_en <= 1'b0;
      pm_addr <= '0;
      pm_wr_data <= '0;
      words_loaded <= '0;
    end else begin
      pm_wr_en <= 1'b0;
      if (restart) begin
        csum <= '0;
        idx <= '0;
        words_loaded <= '0;
      end
      if (xfer) begin
        if (state == LEN_HI) len_hi <= s_data;
        if (state == LEN_LO) len <= n_hdr;
        if (state == DATA_HI) hi <= s_data;
        if (state inside {DATA_HI, DATA_LO}) csum <= csum + s_data;
        if (state == DATA_LO) begin
          pm_wr_en <= 1'b1;
          pm_addr <= ADDR_W'(idx);
          pm_wr_data <= DATA_W'({hi, s_data});
          words_loaded <= words_loaded + 16'd1;
          idx <= idx + 16'd1;
        end
      end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program-memory interface. The processor's fetch path only ever reads program memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit words from it.
- Writes each word sequentially into program memory from address 0 and checks an 8-bit checksum.
- Holds the processor in reset until a load completes successfully, then releases it.

Parameters:
- ADDR_W, 16, program-memory address width.
- DATA_W, 16, program word width. Fixed at 2 bytes per word.
- MAX_WORDS, 65536, largest legal word count. Any header length above this is an error.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-high reset (asserted = 1).
- start  in  1  single-cycle request to begin a load.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a byte this cycle.
- pm_wr_en  out  1  program-memory write strobe, one cycle per word.
- pm_addr  out  ADDR_W  write address.
- pm_wr_data  out  DATA_W  write data.
- cpu_hold  out  1  drives the processor's active-high reset.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed.
- words_loaded  out  16  count of words written in the current/last load.

Behaviour:
- Byte transfer occurs only when s_valid && s_ready. s_valid without s_ready consumes nothing.
- Stream format: LEN_HI, LEN_LO (big-endian word count N), then N × (HI, LO) data bytes, then CSUM.
- CSUM = sum mod 256 of all data bytes. Length bytes are excluded.
- States:
  - IDLE: start -> LEN_HI; clear words_loaded, checksum and index.
  - LEN_HI: on transfer, latch the high length byte -> LEN_LO.
  - LEN_LO: on transfer:
    - N == 0 -> CHECK.
    - N > MAX_WORDS -> ERROR; no writes occur.
    - otherwise -> DATA_HI.
  - DATA_HI: on transfer, latch the byte and add it to the checksum -> DATA_LO.
  - DATA_LO: on transfer, add to the checksum and schedule a write.
    - If index+1 == N -> CHECK, else -> DATA_HI.
    - Increment the index.
  - CHECK: on transfer, received byte == checksum -> DONE, else -> ERROR.
  - DONE, ERROR: start -> LEN_HI with counters cleared. Other inputs are ignored.
- Write timing: pm_wr_en, pm_addr (= index) and pm_wr_data ({hi, lo}) are registered. They are high for exactly one cycle, the cycle after the DATA_LO transfer. words_loaded increments in that same cycle.
- s_ready is registered-free combinational from state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 otherwise.
- Status outputs:
  - busy = 1 in LEN_HI through CHECK.
  - done = 1 only in DONE.
  - error = 1 only in ERROR.
  - cpu_hold = 0 only in DONE, 1 in every other state.
  - On a restart from DONE, cpu_hold rises on the same edge the state leaves DONE.
- start is ignored while busy and ignored in IDLE if it coincides with reset.
- Addresses never wrap, because N ≤ MAX_WORDS ≤ 2^ADDR_W.
- Reset (async, any time, including mid-load):
  - state = IDLE.
  - cpu_hold = 1.
  - s_ready, pm_wr_en, busy, done and error = 0.
  - pm_addr, pm_wr_data and words_loaded = 0.
  - Memory contents already written are not rolled back. A pending write is dropped.
- A failed load leaves partially or fully written memory intact. cpu_hold stays at 1 until a successful load.

Decomposition:
- Package loader_pkg: state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR), BYTE_W = 8, WORD_BYTES = 2.
- Single module; no sub-module is needed. The checksum is an inline 8-bit accumulator.

Test Plan:
- Happy path: reset, start, then bytes 00 03 12 34 AB CD 00 01 BF with s_valid held high.
  - Writes (0, 1234), (1, ABCD), (2, 0001), each one cycle after the LO byte.
  - done = 1, cpu_hold = 0, words_loaded = 3, error = 0.
- Bad checksum: same stream with final byte C0.
  - All 3 writes still occur.
  - error = 1, cpu_hold = 1, done = 0.
- Empty load: 00 00 00.
  - No pm_wr_en; done = 1, cpu_hold = 0, words_loaded = 0.
  - A non-zero final byte instead gives error = 1.
- Handshake gaps: the happy-path stream with s_valid low on random cycles.
  - Identical writes and final status.
  - No byte is consumed while s_valid = 0.
- Reset mid-load: assert rstn after the second write.
  - Outputs go to reset values asynchronously; pm_wr_en never pulses again.
  - A subsequent start plus a full stream loads correctly from address 0.
- Oversize length: MAX_WORDS = 4, stream 00 05.
  - ERROR on the edge after LEN_LO; zero writes; s_ready = 0 afterwards.
  - start then restarts the load.
